// File: rtl/reg_snapshot_serializer.sv
// reg_snapshot_serializer
// Captures a parallel register word on request and streams it out one bit per
// accepted beat over a valid/ready serial interface (readback/drain path of the
// register bank).
//
// Optional feature macro: REG_SNAPSHOT_SERIALIZER_PARITY_EN
//   defined   -> an even-parity beat (XOR of the captured word) follows the data
//                bits and carries ser_last; frame is WIDTH+1 beats.
//   undefined -> no parity state/register; ser_last on data beat WIDTH-1;
//                frame is WIDTH beats.
//
// Outputs are decoded from the registered state only, so the asynchronous clr
// forces every output low immediately, without waiting for a clock edge.

module reg_snapshot_serializer #(
    parameter int WIDTH     = 8,     // bits per snapshot, 2 or more
    parameter bit MSB_FIRST = 1'b1   // 1: bit WIDTH-1 first, 0: bit 0 first
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             snap,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    // Counter must reach WIDTH after the last data beat without wrapping.
    localparam int               CNT_W     = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WIDTH - 1);

`ifdef REG_SNAPSHOT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
`ifdef REG_SNAPSHOT_SERIALIZER_PARITY_EN
    logic             par_q,   par_d;
`endif

    // Datapath strobes produced by the FSM.
    logic load;      // capture par_in into the snapshot
    logic advance;   // a data beat was accepted: shift and count
    logic out_bit;   // bit currently at the output end of the shift register
    logic last_data; // the data beat on the output is beat WIDTH-1

    // Output end of the shift register depends on the bit order.
    always_comb begin
        out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    end

    assign last_data = (cnt_q == LAST_BEAT);

    // FSM next state and Moore outputs decoded from the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        load      = 1'b0;
        advance   = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        ser_data  = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (snap) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_data  = out_bit;
`ifndef REG_SNAPSHOT_SERIALIZER_PARITY_EN
                ser_last  = last_data;
`endif
                if (ser_ready) begin
                    advance = 1'b1;
                    if (last_data) begin
`ifdef REG_SNAPSHOT_SERIALIZER_PARITY_EN
                        state_d = ST_PAR;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end

`ifdef REG_SNAPSHOT_SERIALIZER_PARITY_EN
            ST_PAR: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_data  = par_q;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Snapshot register, beat counter and parity bit next values.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef REG_SNAPSHOT_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif

        if (load) begin
            shreg_d = par_in;
            cnt_d   = '0;
`ifdef REG_SNAPSHOT_SERIALIZER_PARITY_EN
            par_d   = ^par_in;
`endif
        end else if (advance) begin
            // Shift toward the output end, zero filling the vacated bit.
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        // NOTE: the snapshot register is cleared too, not only the FSM, so a
        // frame aborted by clr leaves no stale data behind.
        if (clr) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef REG_SNAPSHOT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others.
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef REG_SNAPSHOT_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_reg_snapshot_serializer.sv
// Testbench for reg_snapshot_serializer (WIDTH=8).
// Two instances share all inputs: one MSB-first, one LSB-first. A frame-level
// reference model pushes the expected beats into queues whenever it predicts a
// capture; a monitor consumes them as the DUTs present beats. Honours
// REG_SNAPSHOT_SERIALIZER_PARITY_EN when the bench is compiled with it.

module tb_reg_snapshot_serializer;

`ifdef REG_SNAPSHOT_SERIALIZER_PARITY_EN
    localparam bit PARITY    = 1'b1;
    localparam int FRAME_LEN = 9;
`else
    localparam bit PARITY    = 1'b0;
    localparam int FRAME_LEN = 8;
`endif

    typedef struct packed {
        logic data;
        logic last;
    } beat_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       snap;
    logic [7:0] par_in;
    logic       ser_ready;

    logic data_m, valid_m, last_m, busy_m;
    logic data_l, valid_l, last_l, busy_l;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: beats still to be transferred in the current frame.
    int    remaining = 0;
    beat_t exp_m[$];
    beat_t exp_l[$];

    // Monitor state.
    int          rd_m = 0;
    int          rd_l = 0;
    logic [15:0] hist_m = '0;
    logic [15:0] hist_l = '0;

    always #5 clk = ~clk;

    reg_snapshot_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk      (clk),
        .clr      (clr),
        .snap     (snap),
        .par_in   (par_in),
        .ser_ready(ser_ready),
        .ser_data (data_m),
        .ser_valid(valid_m),
        .ser_last (last_m),
        .busy     (busy_m)
    );

    reg_snapshot_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk      (clk),
        .clr      (clr),
        .snap     (snap),
        .par_in   (par_in),
        .ser_ready(ser_ready),
        .ser_data (data_l),
        .ser_valid(valid_l),
        .ser_last (last_l),
        .busy     (busy_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of beats; while beats remain, each
    // accepted cycle removes one; only with none remaining is snap honoured.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            remaining = 0;
        end else if (remaining > 0) begin
            if (ser_ready) remaining = remaining - 1;
        end else if (snap) begin
            for (int i = 0; i < 8; i++) begin
                beat_t bm;
                beat_t bl;
                bm.data = par_in[7-i];
                bl.data = par_in[i];
                bm.last = (i == 7) && !PARITY;
                bl.last = (i == 7) && !PARITY;
                exp_m.push_back(bm);
                exp_l.push_back(bl);
            end
            if (PARITY) begin
                beat_t bp;
                bp.data = ^par_in;
                bp.last = 1'b1;
                exp_m.push_back(bp);
                exp_l.push_back(bp);
            end
            remaining = FRAME_LEN;
        end
    end

    // Monitor: compare handshake state every cycle and each presented beat
    // against the head of the expected queue; consume on transfer.
    always @(negedge clk) begin
        if (clr) begin
            rd_m = exp_m.size();
            rd_l = exp_l.size();
        end
        check("busy_m",  busy_m,  remaining > 0);
        check("valid_m", valid_m, remaining > 0);
        check("busy_l",  busy_l,  remaining > 0);
        check("valid_l", valid_l, remaining > 0);
        if (valid_m) begin
            if (rd_m < exp_m.size()) begin
                check("data_m", data_m, exp_m[rd_m].data);
                check("last_m", last_m, exp_m[rd_m].last);
                if (ser_ready) begin
                    hist_m = {hist_m[14:0], data_m};
                    rd_m++;
                end
            end else begin
                check("extra_beat_m", valid_m, 1'b0);
            end
        end
        if (valid_l) begin
            if (rd_l < exp_l.size()) begin
                check("data_l", data_l, exp_l[rd_l].data);
                check("last_l", last_l, exp_l[rd_l].last);
                if (ser_ready) begin
                    hist_l = {hist_l[14:0], data_l};
                    rd_l++;
                end
            end else begin
                check("extra_beat_l", valid_l, 1'b0);
            end
        end
    end

    // Returns at posedge+1 with the DUT idle (bounded).
    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (busy_m && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", busy_m, 1'b0);
    endtask

    // One directed frame; counts cycles with busy high.
    task automatic run_frame(input logic [7:0] word, input int stall_beat, input int stall_len,
                             input bit mid_snap, output int busy_cycles);
        int beat;
        int stall_left;
        wait_idle();
        snap      = 1'b1;
        par_in    = word;
        ser_ready = 1'b1;
        @(posedge clk); #1;
        snap        = 1'b0;
        busy_cycles = 0;
        beat        = 0;
        stall_left  = stall_len;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (beat == stall_beat && stall_left > 0) begin
                ser_ready = 1'b0;
                stall_left--;
            end else begin
                ser_ready = 1'b1;
            end
            if (mid_snap && beat == 3) begin
                snap   = 1'b1;
                par_in = 8'h00;
            end else begin
                snap = 1'b0;
            end
            @(negedge clk);
            if (!busy_m) break;
            busy_cycles++;
            if (ser_ready) beat++;
            @(posedge clk); #1;
        end
        snap = 1'b0;
    endtask

    initial begin
        int bc;
        int idle_run;
        int gaps;
        bit seen;

        clr       = 1'b1;
        snap      = 1'b0;
        par_in    = 8'h00;
        ser_ready = 1'b0;
        #1;
        check("rst_valid", valid_m, 1'b0);
        check("rst_busy",  busy_m,  1'b0);
        check("rst_data",  data_m,  1'b0);
        check("rst_last",  last_m,  1'b0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;

        // Basic frame A5, MSB first and LSB first (A5 is bit-symmetric).
        run_frame(8'hA5, -1, 0, 1'b0, bc);
        check("basic_len", bc, FRAME_LEN);
        if (PARITY) begin
            check("basic_seq_m", hist_m[8:0], {8'hA5, 1'b0});
            check("basic_seq_l", hist_l[8:0], {8'hA5, 1'b0});
        end else begin
            check("basic_seq_m", hist_m[7:0], 8'hA5);
            check("basic_seq_l", hist_l[7:0], 8'hA5);
        end

        // Backpressure: three stall cycles on beat 3.
        run_frame(8'hA5, 2, 3, 1'b0, bc);
        check("bp_len", bc, FRAME_LEN + 3);
        check("bp_seq_m", hist_m[7 + PARITY -: 8], 8'hA5);

        // snap and par_in changes mid-frame are ignored.
        run_frame(8'hA5, -1, 0, 1'b1, bc);
        check("ign_len", bc, FRAME_LEN);
        check("ign_seq_m", hist_m[7 + PARITY -: 8], 8'hA5);
        @(posedge clk); #1;
        check("ign_no_second", busy_m, 1'b0);

        // Bit order with a single set bit.
        run_frame(8'h01, -1, 0, 1'b0, bc);
        if (PARITY) begin
            check("lsb_seq_l", hist_l[8:0], {8'h80, 1'b1});
            check("lsb_seq_m", hist_m[8:0], {8'h01, 1'b1});
        end else begin
            check("lsb_seq_l", hist_l[7:0], 8'h80);
            check("lsb_seq_m", hist_m[7:0], 8'h01);
        end

        // Asynchronous clear mid-frame, between clock edges.
        wait_idle();
        snap   = 1'b1;
        par_in = 8'hFF;
        ser_ready = 1'b1;
        @(posedge clk); #1;
        snap = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("arst_pre_busy", busy_m, 1'b1);
        check("arst_pre_data", data_m, 1'b1);
        clr = 1'b1;
        #1;
        check("arst_valid", valid_m, 1'b0);
        check("arst_data",  data_m,  1'b0);
        check("arst_last",  last_m,  1'b0);
        check("arst_busy",  busy_m,  1'b0);
        check("arst_busy_l", busy_l, 1'b0);
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        check("arst_idle_after", busy_m, 1'b0);
        run_frame(8'hA5, -1, 0, 1'b0, bc);
        check("arst_fresh_len", bc, FRAME_LEN);
        check("arst_fresh_seq", hist_m[7 + PARITY -: 8], 8'hA5);

        // Back-to-back with snap held: exactly one idle cycle between frames.
        wait_idle();
        snap      = 1'b1;
        ser_ready = 1'b1;
        par_in    = 8'($urandom);
        idle_run  = 0;
        gaps      = 0;
        seen      = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy_m) begin
                if (seen && idle_run > 0) begin
                    check("b2b_gap", idle_run, 1);
                    gaps++;
                end
                seen     = 1'b1;
                idle_run = 0;
            end else if (seen) begin
                idle_run++;
            end
            @(posedge clk); #1;
            par_in = 8'($urandom);
        end
        check("b2b_frames", gaps >= 2, 1'b1);
        snap = 1'b0;

        // Randomized traffic with backpressure and occasional clears.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            snap      = ($urandom_range(0, 3) == 0);
            par_in    = 8'($urandom);
            ser_ready = ($urandom_range(0, 3) != 0);
            if (clr) clr = 1'b0;
            else if ($urandom_range(0, 199) == 0) clr = 1'b1;
        end
        clr       = 1'b0;
        snap      = 1'b0;
        ser_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        check("drain_m", rd_m, exp_m.size());
        check("drain_l", rd_l, exp_l.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_snapshot_serializer.md
# reg_snapshot_serializer

Captures a parallel register word on request and shifts it out one bit per accepted beat over a valid/ready serial interface. It is the readback/drain side of the register bank: the bank's flops are written and loaded elsewhere, and this block reads a consistent snapshot and streams it to a serial consumer such as a debug port or scan link.

## Interface
Parameters:
- WIDTH, 8: number of bits captured and serialized; legal range is 2 or more.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset, asynchronous, active-high; clock is clk.
- snap  in  1  capture request; sampled only in IDLE.
- par_in  in  WIDTH  parallel word to snapshot.
- ser_ready  in  1  consumer accepts the current beat.
- ser_data  out  1  current serial bit.
- ser_valid  out  1  ser_data/ser_last are valid.
- ser_last  out  1  current beat is the final beat of the frame.
- busy  out  1  a frame is in progress.

## Operation
- Internal state:
  - shift register shreg[WIDTH-1:0].
  - beat counter cnt, width $clog2(WIDTH+2).
  - FSM with states IDLE, SHIFT, and PAR (PAR exists only with PARITY_EN).
- IDLE:
  - busy=0, ser_valid=0, ser_last=0, ser_data=0.
  - If snap=1 at a rising edge: shreg<=par_in, cnt<=0, go to SHIFT.
  - With PARITY_EN, also latch par<=^par_in.
- SHIFT:
  - busy=1, ser_valid=1.
  - ser_data = shreg[WIDTH-1] if MSB_FIRST=1, else shreg[0].
  - A beat transfers on any rising edge with ser_valid=1 and ser_ready=1.
  - On transfer, shreg shifts toward the output end (zero fill) and cnt increments.
  - Transfer with cnt==WIDTH-1:
    - Go to IDLE if PARITY_EN is undefined.
    - Go to PAR if PARITY_EN is defined.
- PAR:
  - busy=1, ser_valid=1, ser_data=par, ser_last=1.
  - On transfer, go to IDLE.
- ser_last=1 in SHIFT when cnt==WIDTH-1 and PARITY_EN is undefined.
- snap is ignored while busy=1.
- par_in is don't-care after the capture edge; changing it mid-frame has no effect.
- With ser_valid=1 and ser_ready=0, ser_data and ser_last hold stable. No beat is dropped or duplicated.
- ser_ready is ignored while ser_valid=0.

## Timing
- Reset value of every output is 0: ser_data, ser_valid, ser_last, busy.
- Reset also forces FSM=IDLE, shreg=0, cnt=0, par=0.
- clr takes effect immediately, without a clock edge.
- clr asserted mid-frame aborts the frame; no resume.
- After clr falls, the first snap starts a fresh frame from beat 0.
- Latency: snap sampled at edge E0 gives ser_valid=1 and busy=1 in the cycle after E0, with the first bit on ser_data.
- With ser_ready held at 1, frame length is:
  - WIDTH beats without PARITY_EN.
  - WIDTH+1 beats with PARITY_EN.
  - One beat per cycle; busy is high for exactly the frame length in cycles.
- The final transfer edge returns the FSM to IDLE. busy and ser_valid are 0 in the following cycle.
- A snap coincident with the final transfer edge is ignored. The earliest next capture is the edge after that, so there is a one-cycle minimum gap between frames.
- Each backpressure cycle (ser_ready=0 while valid) extends the frame by exactly one cycle.

## Configuration
- Macro: REG_SNAPSHOT_SERIALIZER_PARITY_EN.
- Defined:
  - An even-parity beat (XOR of the captured word) is appended after the data bits.
  - ser_last is asserted on the parity beat only.
  - Frame length is WIDTH+1 beats.
- Undefined:
  - No PAR state and no par register.
  - ser_last is asserted on data beat WIDTH-1.
  - Frame length is WIDTH beats.

## Test plan
- Async reset: run a frame with WIDTH=8 and par_in=8'hFF. Assert clr between clock edges mid-frame -> ser_valid, ser_data, ser_last, busy go to 0 before the next edge; the FSM is IDLE after release.
- Basic frame: WIDTH=8, MSB_FIRST=1, par_in=8'hA5, one-cycle snap, ser_ready=1 ->
  - ser_data sequence is 1,0,1,0,0,1,0,1.
  - ser_last is high on beat 8 only; busy is high for 8 cycles.
  - With PARITY_EN: a 9th beat with ser_data=0, ser_last on beat 9 only, busy high for 9 cycles.
- Backpressure: par_in=8'hA5. Drop ser_ready for 3 cycles while beat 3 (value 1) is presented -> ser_data holds 1 for 4 cycles; the full sequence is unchanged; busy lasts 11 cycles (no parity).
- Ignored inputs: after capturing 8'hA5, pulse snap and change par_in to 8'h00 mid-frame -> the output is still the 8'hA5 sequence and no second frame starts.
- LSB order: MSB_FIRST=0, par_in=8'h01 -> ser_data sequence is 1,0,0,0,0,0,0,0.
- Back-to-back: hold snap=1 continuously -> each frame is followed by exactly one idle cycle (busy=0, ser_valid=0) before the next frame.
